// File: rtl/opmem_pkg.sv
// opmem_pkg: shared encodings for operand-select mode and add/subtract control.
package opmem_pkg;
    typedef enum logic [1:0] {
        OPM_AB   = 2'b00,
        OPM_BOFF = 2'b01,
        OPM_AOFF = 2'b10,
        OPM_ZERO = 2'b11
    } opm_e;
    typedef enum logic {
        AS_ADD = 1'b0,
        AS_SUB = 1'b1
    } add_sub_e;
endpackage

// File: rtl/ula_param.sv
// ula_param: WIDTH-bit adder/subtractor with carry-out and signed overflow.
module ula_param
    import opmem_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             soma_sub,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);
    logic [WIDTH-1:0] b_eff;
    always_comb begin
        b_eff = (soma_sub == AS_SUB) ? ~b : b;
        {carry, result} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, soma_sub};
        overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
    end
endmodule

// File: rtl/operacao_memoria_pipe.sv
// operacao_memoria_pipe: two-stage valid/ready operand-select and add/sub pipeline.
// Define OPMEM_FLAGS_EN to add the {zero, carry, overflow} flags output.
module operacao_memoria_pipe
    import opmem_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int OFFSET_W = 16,
    parameter int TAG_W    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    dinA,
    input  logic [WIDTH-1:0]    dinB,
    input  logic [OFFSET_W-1:0] offset,
    input  logic [1:0]          op_mem_i,
    input  logic                add_sub,
    input  logic [TAG_W-1:0]    tag_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    dout,
    output logic [WIDTH-1:0]    doutA,
    output logic [WIDTH-1:0]    doutB,
    output logic [TAG_W-1:0]    tag_out
`ifdef OPMEM_FLAGS_EN
    ,
    output logic [2:0]          flags
`endif
);
    logic               s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0]   x_q, x_d, y_q, y_d, a1_q, a1_d, b1_q, b1_d;
    logic               as_q, as_d;
    logic [TAG_W-1:0]   t1_q, t1_d, t2_q, t2_d;
    logic [WIDTH-1:0]   dout_q, dout_d, a2_q, a2_d, b2_q, b2_d;
    logic               s1_adv, s2_adv, accept, ld2;
    logic [WIDTH-1:0]   off_ext, sel_x, sel_y, alu_res;
    logic               alu_c, alu_v;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign accept   = in_valid && s1_adv;
    assign ld2      = s2_adv && s1_valid_q;
    assign in_ready = s1_adv;
    assign off_ext  = WIDTH'($signed(offset));
    assign sel_x    = (op_mem_i == OPM_AB || op_mem_i == OPM_AOFF) ? dinA :
                      (op_mem_i == OPM_BOFF) ? dinB : '0;
    assign sel_y    = (op_mem_i == OPM_AB) ? dinB : (op_mem_i == OPM_ZERO) ? '0 : off_ext;

    ula_param #(.WIDTH(WIDTH)) u_ula (
        .a        (x_q),
        .b        (y_q),
        .soma_sub (as_q),
        .result   (alu_res),
        .carry    (alu_c),
        .overflow (alu_v)
    );

    always_comb begin
        s1_valid_d = s1_adv ? in_valid : s1_valid_q;
        x_d        = accept ? sel_x : x_q;
        y_d        = accept ? sel_y : y_q;
        as_d       = accept ? add_sub : as_q;
        a1_d       = accept ? dinA : a1_q;
        b1_d       = accept ? dinB : b1_q;
        t1_d       = accept ? tag_in : t1_q;
        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
        dout_d     = ld2 ? alu_res : dout_q;
        a2_d       = ld2 ? a1_q : a2_q;
        b2_d       = ld2 ? b1_q : b2_q;
        t2_d       = ld2 ? t1_q : t2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            as_q       <= 1'b0;
            a1_q       <= '0;
            b1_q       <= '0;
            t1_q       <= '0;
            dout_q     <= '0;
            a2_q       <= '0;
            b2_q       <= '0;
            t2_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            x_q        <= x_d;
            y_q        <= y_d;
            as_q       <= as_d;
            a1_q       <= a1_d;
            b1_q       <= b1_d;
            t1_q       <= t1_d;
            dout_q     <= dout_d;
            a2_q       <= a2_d;
            b2_q       <= b2_d;
            t2_q       <= t2_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign dout      = dout_q;
    assign doutA     = a2_q;
    assign doutB     = b2_q;
    assign tag_out   = t2_q;

`ifdef OPMEM_FLAGS_EN
    logic [2:0] flags_q, flags_d;
    assign flags_d = ld2 ? {alu_res == '0, alu_c, alu_v} : flags_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flags_q <= '0;
        else        flags_q <= flags_d;
    end
    assign flags = flags_q;
`else
    logic unused_alu_flags;
    assign unused_alu_flags = alu_c ^ alu_v;
`endif
endmodule

// File: tb/tb_operacao_memoria_pipe.sv
// tb_operacao_memoria_pipe: directed scoreboard bench for the two-stage add/sub pipeline.
module tb_operacao_memoria_pipe;
    localparam int W  = 64;
    localparam int OW = 16;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0, in_ready;
    logic [W-1:0]  dinA = '0, dinB = '0;
    logic [OW-1:0] offset = '0;
    logic [1:0]    op_mem_i = '0;
    logic          add_sub = 1'b0;
    logic [TW-1:0] tag_in = '0;
    logic          out_valid, out_ready = 1'b0;
    logic [W-1:0]  dout, doutA, doutB;
    logic [TW-1:0] tag_out;
`ifdef OPMEM_FLAGS_EN
    logic [2:0]    flags;
`endif

    always #5 clk = ~clk;

    operacao_memoria_pipe #(.WIDTH(W), .OFFSET_W(OW), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dinA      (dinA),
        .dinB      (dinB),
        .offset    (offset),
        .op_mem_i  (op_mem_i),
        .add_sub   (add_sub),
        .tag_in    (tag_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .doutA     (doutA),
        .doutB     (doutB),
        .tag_out   (tag_out)
`ifdef OPMEM_FLAGS_EN
        ,
        .flags     (flags)
`endif
    );

    typedef struct {
        logic [W-1:0]  d, a, b;
        logic [TW-1:0] t;
        logic [2:0]    f;
        int            cyc;
        bit            lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, failures = 0, cyc = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: signed 65-bit arithmetic for overflow, unsigned compare for borrow.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [OW-1:0] off,
                                   input logic [1:0] op, input logic as, input logic [TW-1:0] t);
        exp_t m;
        logic [W-1:0] oe, x, y;
        logic signed [W:0] sx, sy, r;
        logic [W:0] u;
        oe = {{(W-OW){off[OW-1]}}, off};
        x = (op == 2'd0 || op == 2'd2) ? a : (op == 2'd1) ? b : '0;
        y = (op == 2'd0) ? b : (op == 2'd3) ? '0 : oe;
        sx = {x[W-1], x};
        sy = {y[W-1], y};
        r = as ? sx - sy : sx + sy;
        u = {1'b0, x} + {1'b0, y};
        m.d = r[W-1:0];
        m.a = a;
        m.b = b;
        m.t = t;
        m.f = {m.d == '0, as ? (x >= y) : u[W], r[W] != r[W-1]};
        m.cyc = 0;
        m.lat = 1'b0;
        return m;
    endfunction

    task automatic step(input bit iv, input logic [W-1:0] a, input logic [W-1:0] b, input logic [OW-1:0] off,
                        input logic [1:0] op, input logic as, input logic [TW-1:0] t,
                        input bit ordy, input bit lat, output bit acc);
        exp_t e;
        @(negedge clk);
        in_valid = iv; dinA = a; dinB = b; offset = off; op_mem_i = op; add_sub = as; tag_in = t;
        out_ready = ordy;
        #1;
        chk("in_ready", W'(in_ready), W'(!(sb.size() == 2 && !ordy)));
        if (sb.size() == 0) chk("bubble_valid", W'(out_valid), '0);
        else begin
            e = sb[0];
            if (e.lat) chk("out_valid_timing", W'(out_valid), W'(cyc - e.cyc >= 2));
            if (out_valid) begin
                chk("dout", dout, e.d);
                chk("doutA", doutA, e.a);
                chk("doutB", doutB, e.b);
                chk("tag_out", W'(tag_out), W'(e.t));
`ifdef OPMEM_FLAGS_EN
                chk("flags", W'(flags), W'(e.f));
`endif
                if (ordy) begin
                    if (e.lat) chk("latency", W'(cyc - e.cyc), W'(2));
                    void'(sb.pop_front());
                end
            end
        end
        acc = iv && in_ready;
        if (acc) begin
            e = model(a, b, off, op, as, t);
            e.cyc = cyc;
            e.lat = lat;
            sb.push_back(e);
        end
        cyc++;
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 20 && sb.size() > 0; i++) step(0, '0, '0, '0, 2'd0, 1'b0, '0, 1'b1, 1'b0, acc);
        chk("drain_empty", W'(sb.size()), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit            acc;
        logic [3:0]    pat;
        int            tg, n;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", W'(out_valid), '0);
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_dout", dout, '0);
        chk("rst_doutA", doutA, '0);
        chk("rst_doutB", doutB, '0);
        chk("rst_tag_out", W'(tag_out), '0);
`ifdef OPMEM_FLAGS_EN
        chk("rst_flags", W'(flags), '0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        step(1, 64'd5, 64'd3, '0, 2'd0, 1'b0, 4'd1, 1'b1, 1'b1, acc);
        drain();

        step(1, '0, 64'h100, 16'hFFF0, 2'd1, 1'b0, 4'd2, 1'b1, 1'b1, acc);
        step(1, 64'h10, '0, 16'h0010, 2'd2, 1'b1, 4'd3, 1'b1, 1'b1, acc);
        step(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, '0, 2'd0, 1'b0, 4'd4, 1'b1, 1'b1, acc);
        step(1, 64'hDEAD_BEEF, 64'h1234, 16'h8000, 2'd3, 1'b0, 4'd5, 1'b1, 1'b1, acc);
        step(1, 64'hDEAD_BEEF, 64'h1234, 16'h8000, 2'd3, 1'b1, 4'd6, 1'b1, 1'b1, acc);
        step(1, 64'd3, 64'd7, 16'h7FFF, 2'd0, 1'b1, 4'd7, 1'b1, 1'b1, acc);
        step(1, 64'h8000_0000_0000_0000, 64'd1, '0, 2'd0, 1'b1, 4'd8, 1'b1, 1'b1, acc);
        drain();

        for (int i = 0; i < 40; i++)
            step($urandom_range(0, 1) == 1, {$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom),
                 2'($urandom), 1'($urandom), 4'($urandom), $urandom_range(0, 2) != 0, 1'b0, acc);
        drain();

        pat = 4'b1001;
        tg = 0;
        n = 0;
        while (tg < 16 && n < 200) begin
            step(1, {$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom), 2'($urandom), 1'($urandom),
                 4'(tg), pat[n % 4], 1'b0, acc);
            if (acc) tg++;
            n++;
        end
        chk("tags_all_sent", W'(tg), W'(16));
        drain();

        step(1, 64'd10, 64'd20, '0, 2'd0, 1'b0, 4'd9, 1'b1, 1'b0, acc);
        step(1, 64'd30, 64'd40, '0, 2'd0, 1'b0, 4'd10, 1'b1, 1'b0, acc);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", W'(out_valid), '0);
        chk("midrst_in_ready", W'(in_ready), W'(1));
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(0, '0, '0, '0, 2'd0, 1'b0, '0, 1'b1, 1'b0, acc);
        step(1, 64'd1, 64'd1, '0, 2'd0, 1'b0, 4'd11, 1'b1, 1'b1, acc);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/operacao_memoria_pipe.md
OPERACAO_MEMORIA_PIPE -- requirements
Module: operacao_memoria_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 64, datapath width in bits.
REQ-002 SHALL have parameter OFFSET_W, default 16, width of the immediate offset.
REQ-003 SHALL have parameter TAG_W, default 4, width of the sideband tag.
REQ-004 SHALL have ports, one clock, asynchronous active-low reset:
  clk  in  1  rising-edge clock
  rst_n  in  1  asynchronous active-low reset
  in_valid  in  1  request present
  in_ready  out  1  request accepted when in_valid&in_ready
  dinA  in  WIDTH  register Ra value
  dinB  in  WIDTH  register Rb value
  offset  in  OFFSET_W  signed immediate
  op_mem_i  in  2  operand-select mode
  add_sub  in  1  0=add, 1=subtract
  tag_in  in  TAG_W  sideband, returned with result
  out_valid  out  1  result present
  out_ready  in  1  result consumed when out_valid&out_ready
  dout  out  WIDTH  arithmetic result
  doutA  out  WIDTH  dinA of the same request
  doutB  out  WIDTH  dinB of the same request
  tag_out  out  TAG_W  tag_in of the same request
  flags  out  3  {zero, carry, overflow}; present only with OPMEM_FLAGS_EN

Function
REQ-005 SHALL sign-extend offset to WIDTH bits before use.
REQ-006 SHALL select operands (X,Y) by op_mem_i: 00 (dinA,dinB); 01 (dinB,offset); 10 (dinA,offset); 11 (0,0).
REQ-007 SHALL compute dout = X+Y if add_sub=0, X-Y (X+~Y+1) if add_sub=1, modulo 2^WIDTH.
REQ-008 SHALL be two pipeline stages: S1 registers selected operands, add_sub, dinA, dinB, tag; S2 registers result and passthroughs.
REQ-009 SHALL present the result 2 cycles after acceptance when out_ready is held high.
REQ-010 SHALL sustain one accepted request per cycle with out_ready continuously high.
REQ-011 SHALL advance S2 when S2 empty or out_ready=1; S1 advances when S1 empty or S2 advances.
REQ-012 SHALL drive in_ready = !s1_valid | s2_advance (combinational from out_ready allowed).
REQ-013 SHALL hold dout, doutA, doutB, tag_out, flags stable while out_valid=1 and out_ready=0.
REQ-014 SHALL deliver results in acceptance order; none dropped or duplicated under any stall pattern.
REQ-015 SHALL ignore data inputs when in_valid=0; pipe bubbles SHALL NOT produce out_valid.
REQ-016 SHALL accept a new request and emit the held result in the same cycle when full and out_ready=1.

Reset
REQ-017 SHALL on rst_n=0 immediately clear all stage-valid bits: out_valid=0, in_ready=1 after release.
REQ-018 SHALL reset dout, doutA, doutB, tag_out, flags to 0.
REQ-019 SHALL discard in-flight requests on reset mid-operation; no partial result emitted after release.

Configuration
REQ-020 SHALL, when OPMEM_FLAGS_EN is defined, compute in S2: zero=(dout==0); carry=adder carry-out (add) or carry-out of X+~Y+1 (subtract, 1 = no borrow); overflow=signed overflow of the operation.
REQ-021 SHALL, when OPMEM_FLAGS_EN is undefined, omit the flags port and its logic entirely.

Structure
REQ-022 SHALL place op_mem_i encodings (OPM_AB, OPM_BOFF, OPM_AOFF, OPM_ZERO) and add_sub encodings in shared package opmem_pkg.
REQ-023 SHALL implement the adder as one sub-module ula_param (WIDTH parameter, a, b, soma_sub in; result, carry, overflow out).

Verification
REQ-024 Reset then op=00, A=5, B=3, add -> out_valid on cycle 2, dout=8, doutA=5, doutB=3.
REQ-025 op=01, B=0x100, offset=16'hFFF0, add -> dout=0xF0; op=10, A=0x10, offset=0x10, sub -> dout=0 (flags zero=1, carry=1).
REQ-026 op=00, A=0x7FFF_FFFF_FFFF_FFFF, B=1, add -> dout=0x8000_0000_0000_0000, overflow=1, carry=0; op=11 either add_sub -> dout=0.
REQ-027 Back-to-back tags 0..15 with out_ready toggling 1,0,0,1 -> tags out in order 0..15, outputs stable during stalls, in_ready=0 only when both stages full.
REQ-028 Two requests in flight, assert rst_n=0 mid-cycle -> out_valid=0 immediately; after release no stale result, next request (A=1,B=1) yields dout=2.
